// File: rtl/pe_dispatch_pkg.sv
// Shared types for the PE command dispatcher: FSM states, queued command entry
// layout and counter widths.
package pe_dispatch_pkg;

    localparam int WORD_WIDTH       = 32;
    localparam int DONE_COUNT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2
    } dispatch_state_t;

    // One queued command: opcode word plus its three arguments (128 bits)
    typedef struct packed {
        logic [WORD_WIDTH-1:0] command;
        logic [WORD_WIDTH-1:0] argument_1;
        logic [WORD_WIDTH-1:0] argument_2;
        logic [WORD_WIDTH-1:0] argument_3;
    } cmd_entry_t;

endpackage

// File: rtl/pe_command_dispatcher_if.sv
// Host-side command offer bus: valid/ready handshake carrying a command and
// three arguments. The host drives the master side, the dispatcher the slave.
interface pe_command_dispatcher_if;
    import pe_dispatch_pkg::*;

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [WORD_WIDTH-1:0] cmd_command;
    logic [WORD_WIDTH-1:0] cmd_argument_1;
    logic [WORD_WIDTH-1:0] cmd_argument_2;
    logic [WORD_WIDTH-1:0] cmd_argument_3;

    modport master (
        output cmd_valid, cmd_command, cmd_argument_1, cmd_argument_2, cmd_argument_3,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_command, cmd_argument_1, cmd_argument_2, cmd_argument_3,
        output cmd_ready
    );
endinterface

// File: rtl/pe_command_fifo.sv
// Small synchronous circular FIFO of command entries. The head entry is
// presented combinationally so the consumer can capture it on the pop edge.
module pe_command_fifo
    import pe_dispatch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   push,
    input  cmd_entry_t             push_data,
    input  logic                   pop,
    output cmd_entry_t             head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int PTR_WIDTH = $clog2(DEPTH);

    logic [PTR_WIDTH-1:0] wr_ptr_reg;
    logic [PTR_WIDTH-1:0] rd_ptr_reg;
    logic [PTR_WIDTH:0]   level_reg;
    logic                 push_ok;
    logic                 pop_ok;
    cmd_entry_t           slots [DEPTH];

    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            cmd_entry_t slot_reg;
            // Each slot captures the incoming entry when the write pointer lands on it
            always_ff @(posedge clock) begin
                if (push_ok && wr_ptr_reg == PTR_WIDTH'(gi)) begin
                    slot_reg <= push_data;
                end
            end
            assign slots[gi] = slot_reg;
        end
    endgenerate

    // Pointer and occupancy bookkeeping; pointers wrap naturally at the power-of-2 depth
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_WIDTH'(1);
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PTR_WIDTH'(1);
            case ({push_ok, pop_ok})
                2'b10:   level_reg <= level_reg + (PTR_WIDTH+1)'(1);
                2'b01:   level_reg <= level_reg - (PTR_WIDTH+1)'(1);
                default: level_reg <= level_reg;
            endcase
        end
    end

    assign head  = slots[rd_ptr_reg];
    assign full  = (level_reg == (PTR_WIDTH+1)'(DEPTH));
    assign empty = (level_reg == '0);
    assign level = level_reg;

endmodule

// File: rtl/pe_command_dispatcher.sv
// Queues host commands and issues them to the PE one at a time: a one-cycle
// start pulse, then wait for command_done or a watchdog expiry.
module pe_command_dispatcher
    import pe_dispatch_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                        clock,
    input  logic                        reset_n,
    pe_command_dispatcher_if.slave      host,
    output logic                        start,
    output logic [WORD_WIDTH-1:0]       command,
    output logic [WORD_WIDTH-1:0]       argument_1,
    output logic [WORD_WIDTH-1:0]       argument_2,
    output logic [WORD_WIDTH-1:0]       argument_3,
    input  logic                        command_done,
    input  logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        idle,
    output logic [DONE_COUNT_WIDTH-1:0] done_count,
    output logic                        timeout_error,
    input  logic                        timeout_clear
);
    localparam int TIMER_WIDTH = $clog2(TIMEOUT_CYCLES);
    localparam logic [TIMER_WIDTH-1:0] TIMER_LAST = TIMER_WIDTH'(TIMEOUT_CYCLES - 1);

    dispatch_state_t             state_reg;
    cmd_entry_t                  issued_reg;
    logic                        start_reg;
    logic [TIMER_WIDTH-1:0]      timer_reg;
    logic [DONE_COUNT_WIDTH-1:0] done_count_reg;
    logic                        timeout_error_reg;

    cmd_entry_t push_entry;
    cmd_entry_t fifo_head;
    logic       fifo_full;
    logic       fifo_empty;
    logic       push;
    logic       pop;

    assign push_entry = '{command:    host.cmd_command,
                          argument_1: host.cmd_argument_1,
                          argument_2: host.cmd_argument_2,
                          argument_3: host.cmd_argument_3};

    // Ready follows the registered level only, so a same-cycle pop never re-opens a full queue
    assign host.cmd_ready = reset_n && !fifo_full;
    assign push           = host.cmd_valid && host.cmd_ready;
    assign pop            = (state_reg == IDLE) && !fifo_empty && !busy;

    pe_command_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    // Issue FSM with watchdog, completion counter and sticky timeout flag
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_reg         <= IDLE;
            issued_reg        <= '0;
            start_reg         <= 1'b0;
            timer_reg         <= '0;
            done_count_reg    <= '0;
            timeout_error_reg <= 1'b0;
        end else begin
            start_reg <= 1'b0;
            // A clear is overridden below if the watchdog expires on the same edge
            if (timeout_clear) timeout_error_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (pop) begin
                        issued_reg <= fifo_head;
                        start_reg  <= 1'b1;
                        state_reg  <= ISSUE;
                    end
                end
                ISSUE: begin
                    timer_reg <= '0;
                    state_reg <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (command_done) begin
                        done_count_reg <= done_count_reg + DONE_COUNT_WIDTH'(1);
                        state_reg      <= IDLE;
                    end else if (timer_reg == TIMER_LAST) begin
                        timeout_error_reg <= 1'b1;
                        state_reg         <= IDLE;
                    end else begin
                        timer_reg <= timer_reg + TIMER_WIDTH'(1);
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign start         = start_reg;
    assign command       = issued_reg.command;
    assign argument_1    = issued_reg.argument_1;
    assign argument_2    = issued_reg.argument_2;
    assign argument_3    = issued_reg.argument_3;
    assign done_count    = done_count_reg;
    assign timeout_error = timeout_error_reg;
    assign idle          = (state_reg == IDLE) && (fifo_level == '0);

endmodule

// File: tb/tb_pe_command_dispatcher.sv
// Directed bench for pe_command_dispatcher (FIFO_DEPTH=4, TIMEOUT_CYCLES=8).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_pe_command_dispatcher;
    import pe_dispatch_pkg::*;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start;
    logic [31:0] command, argument_1, argument_2, argument_3;
    logic        command_done = 1'b0;
    logic        busy = 1'b0;
    logic [2:0]  fifo_level;
    logic        idle;
    logic [15:0] done_count;
    logic        timeout_error;
    logic        timeout_clear = 1'b0;

    int checks = 0;
    int failures = 0;

    pe_command_dispatcher_if host_if ();

    pe_command_dispatcher #(
        .FIFO_DEPTH     (4),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .host          (host_if),
        .start         (start),
        .command       (command),
        .argument_1    (argument_1),
        .argument_2    (argument_2),
        .argument_3    (argument_3),
        .command_done  (command_done),
        .busy          (busy),
        .fifo_level    (fifo_level),
        .idle          (idle),
        .done_count    (done_count),
        .timeout_error (timeout_error),
        .timeout_clear (timeout_clear)
    );

    always #5 clock = ~clock;

    task automatic set_cmd(input logic [31:0] c, input logic [31:0] a1,
                           input logic [31:0] a2, input logic [31:0] a3);
        host_if.cmd_command    = c;
        host_if.cmd_argument_1 = a1;
        host_if.cmd_argument_2 = a2;
        host_if.cmd_argument_3 = a3;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        checks++; if (start !== 1'b0) begin failures++; $display("FAIL reset_start got=%b exp=0", start); end
        checks++; if (command !== 32'h0) begin failures++; $display("FAIL reset_command got=%h exp=0", command); end
        checks++; if (fifo_level !== 3'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", fifo_level); end
        checks++; if (done_count !== 16'd0) begin failures++; $display("FAIL reset_done_count got=%0d exp=0", done_count); end
        checks++; if (timeout_error !== 1'b0) begin failures++; $display("FAIL reset_timeout got=%b exp=0", timeout_error); end
        checks++; if (host_if.cmd_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", host_if.cmd_ready); end
        checks++; if (idle !== 1'b1) begin failures++; $display("FAIL reset_idle got=%b exp=1", idle); end
        reset_n = 1'b1;
        @(negedge clock);
        checks++; if (host_if.cmd_ready !== 1'b1) begin failures++; $display("FAIL post_reset_ready got=%b exp=1", host_if.cmd_ready); end
        $display("reset released");
    endtask

    task automatic test_single();
        host_if.cmd_valid = 1'b1;
        set_cmd(32'h0000_0011, 32'd1, 32'd2, 32'd3);
        @(negedge clock);                       // edge N accepted the command
        host_if.cmd_valid = 1'b0;
        checks++; if (fifo_level !== 3'd1) begin failures++; $display("FAIL single_level got=%0d exp=1", fifo_level); end
        checks++; if (start !== 1'b0) begin failures++; $display("FAIL single_early_start got=%b exp=0", start); end
        @(negedge clock);                       // cycle N+2: start high
        checks++; if (start !== 1'b1) begin failures++; $display("FAIL single_start got=%b exp=1", start); end
        checks++; if (command !== 32'h11) begin failures++; $display("FAIL single_command got=%h exp=11", command); end
        checks++; if ({argument_1, argument_2, argument_3} !== {32'd1, 32'd2, 32'd3})
            begin failures++; $display("FAIL single_args got=%0d,%0d,%0d exp=1,2,3", argument_1, argument_2, argument_3); end
        checks++; if (fifo_level !== 3'd0) begin failures++; $display("FAIL single_level_after_pop got=%0d exp=0", fifo_level); end
        @(negedge clock);
        checks++; if (start !== 1'b0) begin failures++; $display("FAIL single_start_width got=%b exp=0", start); end
        checks++; if (command !== 32'h11) begin failures++; $display("FAIL single_command_hold got=%h exp=11", command); end
        repeat (4) @(negedge clock);
        command_done = 1'b1;
        @(negedge clock);
        command_done = 1'b0;
        checks++; if (done_count !== 16'd1) begin failures++; $display("FAIL single_done_count got=%0d exp=1", done_count); end
        checks++; if (idle !== 1'b1) begin failures++; $display("FAIL single_idle got=%b exp=1", idle); end
        $display("single command 0x11 issued and completed");
    endtask

    task automatic test_reset_mid();
        host_if.cmd_valid = 1'b1;
        set_cmd(32'h21, 32'h0, 32'h0, 32'h0);
        @(negedge clock);
        set_cmd(32'h22, 32'h0, 32'h0, 32'h0);
        @(negedge clock);
        set_cmd(32'h23, 32'h0, 32'h0, 32'h0);
        @(negedge clock);
        host_if.cmd_valid = 1'b0;
        @(negedge clock);                       // 0x21 in WAIT_DONE, two queued
        checks++; if (fifo_level !== 3'd2) begin failures++; $display("FAIL mid_level_before got=%0d exp=2", fifo_level); end
        reset_n = 1'b0;
        @(negedge clock);
        checks++; if (fifo_level !== 3'd0) begin failures++; $display("FAIL mid_reset_level got=%0d exp=0", fifo_level); end
        checks++; if (start !== 1'b0) begin failures++; $display("FAIL mid_reset_start got=%b exp=0", start); end
        checks++; if (command !== 32'h0) begin failures++; $display("FAIL mid_reset_command got=%h exp=0", command); end
        checks++; if (idle !== 1'b1) begin failures++; $display("FAIL mid_reset_idle got=%b exp=1", idle); end
        checks++; if (done_count !== 16'd0) begin failures++; $display("FAIL mid_reset_done_count got=%0d exp=0", done_count); end
        reset_n = 1'b1;
        @(negedge clock);
        $display("reset during WAIT_DONE with 2 queued");
    endtask

    task automatic test_full();
        bit found;
        busy = 1'b1;
        host_if.cmd_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_cmd(32'h100 + i, 32'h1000 + i, 32'h2000 + i, 32'h3000 + i);
            @(negedge clock);
        end
        set_cmd(32'h104, 32'h1004, 32'h2004, 32'h3004);
        checks++; if (fifo_level !== 3'd4) begin failures++; $display("FAIL full_level got=%0d exp=4", fifo_level); end
        checks++; if (host_if.cmd_ready !== 1'b0) begin failures++; $display("FAIL full_ready got=%b exp=0", host_if.cmd_ready); end
        repeat (2) @(negedge clock);
        checks++; if (fifo_level !== 3'd4) begin failures++; $display("FAIL full_hold_level got=%0d exp=4", fifo_level); end
        checks++; if (start !== 1'b0) begin failures++; $display("FAIL busy_blocks_start got=%b exp=0", start); end
        busy = 1'b0;
        @(negedge clock);                       // head popped and issued
        checks++; if (start !== 1'b1 || command !== 32'h100)
            begin failures++; $display("FAIL full_issue0 got=%b/%h exp=1/100", start, command); end
        checks++; if (fifo_level !== 3'd3) begin failures++; $display("FAIL full_after_pop_level got=%0d exp=3", fifo_level); end
        checks++; if (host_if.cmd_ready !== 1'b1) begin failures++; $display("FAIL full_reopen_ready got=%b exp=1", host_if.cmd_ready); end
        @(negedge clock);                       // fifth command accepted
        host_if.cmd_valid = 1'b0;
        checks++; if (fifo_level !== 3'd4) begin failures++; $display("FAIL full_fifth_accept got=%0d exp=4", fifo_level); end
        command_done = 1'b1;
        @(negedge clock);
        command_done = 1'b0;
        $display("issued cmd=%h", 32'h100);
        for (int k = 1; k < 5; k++) begin
            found = 1'b0;
            for (int w = 0; w < 10 && !found; w++) begin
                @(negedge clock);
                if (start === 1'b1) found = 1'b1;
            end
            checks++; if (!found) begin failures++; $display("FAIL full_issue_wait k=%0d got=no_start exp=start", k); end
            checks++; if (command !== 32'h100 + k || argument_3 !== 32'h3000 + k)
                begin failures++; $display("FAIL full_order k=%0d got=%h/%h exp=%h/%h", k, command, argument_3, 32'h100 + k, 32'h3000 + k); end
            $display("issued cmd=%h", command);
            @(negedge clock);
            command_done = 1'b1;
            @(negedge clock);
            command_done = 1'b0;
        end
        checks++; if (done_count !== 16'd5) begin failures++; $display("FAIL full_done_count got=%0d exp=5", done_count); end
        checks++; if (idle !== 1'b1) begin failures++; $display("FAIL full_idle got=%b exp=1", idle); end
    endtask

    task automatic test_timeout();
        host_if.cmd_valid = 1'b1;
        set_cmd(32'h200, 32'h0, 32'h0, 32'h0);
        @(negedge clock);
        set_cmd(32'h201, 32'h0, 32'h0, 32'h0);
        @(negedge clock);
        host_if.cmd_valid = 1'b0;
        checks++; if (start !== 1'b1 || command !== 32'h200)
            begin failures++; $display("FAIL to_issue got=%b/%h exp=1/200", start, command); end
        repeat (8) @(negedge clock);            // 7 WAIT_DONE cycles elapsed
        checks++; if (timeout_error !== 1'b0) begin failures++; $display("FAIL to_early got=%b exp=0", timeout_error); end
        @(negedge clock);                       // 8th WAIT_DONE cycle expired
        checks++; if (timeout_error !== 1'b1) begin failures++; $display("FAIL to_set got=%b exp=1", timeout_error); end
        @(negedge clock);
        checks++; if (start !== 1'b1 || command !== 32'h201)
            begin failures++; $display("FAIL to_next_issue got=%b/%h exp=1/201", start, command); end
        checks++; if (done_count !== 16'd5) begin failures++; $display("FAIL to_done_count got=%0d exp=5", done_count); end
        @(negedge clock);
        command_done = 1'b1;
        @(negedge clock);
        command_done = 1'b0;
        checks++; if (done_count !== 16'd6) begin failures++; $display("FAIL to_next_done got=%0d exp=6", done_count); end
        checks++; if (timeout_error !== 1'b1) begin failures++; $display("FAIL to_sticky got=%b exp=1", timeout_error); end
        timeout_clear = 1'b1;
        @(negedge clock);
        timeout_clear = 1'b0;
        checks++; if (timeout_error !== 1'b0) begin failures++; $display("FAIL to_clear got=%b exp=0", timeout_error); end
        $display("timeout on cmd=200, cmd=201 completed");
    endtask

    task automatic test_done_on_expiry();
        host_if.cmd_valid = 1'b1;
        set_cmd(32'h300, 32'h0, 32'h0, 32'h0);
        @(negedge clock);
        host_if.cmd_valid = 1'b0;
        @(negedge clock);
        checks++; if (start !== 1'b1) begin failures++; $display("FAIL exp_issue got=%b exp=1", start); end
        repeat (8) @(negedge clock);
        command_done = 1'b1;                    // sampled on the expiry edge
        @(negedge clock);
        command_done = 1'b0;
        checks++; if (done_count !== 16'd7) begin failures++; $display("FAIL exp_done_count got=%0d exp=7", done_count); end
        checks++; if (timeout_error !== 1'b0) begin failures++; $display("FAIL exp_no_timeout got=%b exp=0", timeout_error); end
        checks++; if (idle !== 1'b1) begin failures++; $display("FAIL exp_idle got=%b exp=1", idle); end
        command_done = 1'b1;                    // stray pulse while IDLE
        @(negedge clock);
        command_done = 1'b0;
        @(negedge clock);
        checks++; if (done_count !== 16'd7) begin failures++; $display("FAIL idle_done_ignored got=%0d exp=7", done_count); end
        $display("done on expiry counted, idle done ignored");
    endtask

    task automatic test_wrap();
        force dut.done_count_reg = 16'hFFFF;
        @(negedge clock);
        release dut.done_count_reg;
        @(negedge clock);
        checks++; if (done_count !== 16'hFFFF) begin failures++; $display("FAIL wrap_preload got=%h exp=ffff", done_count); end
        host_if.cmd_valid = 1'b1;
        set_cmd(32'h400, 32'h0, 32'h0, 32'h0);
        @(negedge clock);
        host_if.cmd_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        command_done = 1'b1;
        @(negedge clock);
        command_done = 1'b0;
        checks++; if (done_count !== 16'h0000) begin failures++; $display("FAIL wrap_done_count got=%h exp=0000", done_count); end
        $display("done_count wrapped ffff->0");
    endtask

    initial begin
        host_if.cmd_valid = 1'b0;
        set_cmd(32'h0, 32'h0, 32'h0, 32'h0);
        test_reset();
        test_single();
        test_reset_mid();
        test_full();
        test_timeout();
        test_done_on_expiry();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_time_limit got=expired exp=finish");
        $fatal(1, "time limit");
    end

endmodule
